// File: rtl/countdown_timer_pkg.sv
// Shared definitions for countdown_timer: FSM state encoding and default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package countdown_timer_pkg;

   // 2-bit state encoding, fixed values so other blocks and debug tools can decode it
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/countdown_timer.sv
// Loadable countdown timer: load a terminal count, start, count down to zero, pulse done.
// Latency: done is high exactly N edges after the edge that samples start (N = loaded value).
// Backpressure: load_ready is high only in IDLE/ARMED; loads offered in RUN/DONE are not taken.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   load_valid/load_value load request and terminal count (unsigned)
//   load_ready            load accepted this cycle when load_valid is high
//   start, pause, abort   run control (start only in ARMED, pause only in RUN)
//   count                 remaining count
//   busy, done            high in RUN; one-cycle pulse in DONE
// Build option: define COUNTDOWN_TIMER_AUTORELOAD_EN to make DONE restart RUN from the
// last loaded value (period N+1); otherwise DONE always returns to IDLE.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   output logic             load_ready,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_nxt;
`endif

   always_comb begin
      state_nxt = state;
      count_nxt = count;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_nxt = reload;
`endif
      case (state)
         // start/pause/abort have no meaning before anything is loaded
         IDLE: begin
            if (load_valid) begin
               state_nxt = ARMED;
               count_nxt = load_value;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
               reload_nxt = load_value;
`endif
            end
         end
         // abort beats load, and load beats start
         ARMED: begin
            if (abort) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (load_valid) begin
               count_nxt = load_value;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
               reload_nxt = load_value;
`endif
            end else if (start) begin
               // a zero count has nothing to run, so it expires immediately
               state_nxt = (count != '0) ? RUN : DONE;
            end
         end
         // leaving on the 1->0 step means the decrement can never wrap
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (!pause) begin
               count_nxt = count - WIDTH'(1);
               if (count == WIDTH'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         // done is decoded from this state, so it always lasts exactly this one cycle
         DONE: begin
            state_nxt = IDLE;
            count_nxt = '0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            if (!abort && (reload != '0)) begin
               state_nxt = RUN;
               count_nxt = reload;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
         reload <= '0;
`endif
      end else begin
         state <= state_nxt;
         count <= count_nxt;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
         reload <= reload_nxt;
`endif
      end
   end

   assign load_ready = (state == IDLE) || (state == ARMED);
   assign busy       = (state == RUN);
   assign done       = (state == DONE);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the width of the counter and load datapath.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset: synchronous, active-high; clock clk.
REQ-004 SHALL have port load_valid  input  1  request to load load_value.
REQ-005 SHALL have port load_value  input  WIDTH  terminal count to load, unsigned.
REQ-006 SHALL have port load_ready  output  1  load accepted this cycle if load_valid is high.
REQ-007 SHALL have port start  input  1  begin countdown, sampled in ARMED only.
REQ-008 SHALL have port pause  input  1  hold count while RUN.
REQ-009 SHALL have port abort  input  1  cancel the countdown and return to IDLE.
REQ-010 SHALL have port count  output  WIDTH  current remaining count.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on expiry.

Function
REQ-013 SHALL implement the FSM states IDLE, ARMED, RUN and DONE; all outputs SHALL be registered or decoded from registered state.
REQ-014 In IDLE and ARMED, load_ready SHALL be 1; in RUN and DONE, load_ready SHALL be 0.
REQ-015 On a load handshake (load_valid & load_ready), count and an internal reload register SHALL take load_value, and the FSM SHALL go to ARMED; a load in ARMED SHALL overwrite the previous value.
REQ-016 In ARMED with start=1 and no load: if count>0, the FSM SHALL go to RUN with count unchanged; if count==0, it SHALL go directly to DONE.
REQ-017 If load_valid and start are high together in ARMED, the load SHALL win and start SHALL be ignored.
REQ-018 In RUN with pause=0, count SHALL decrement by 1 per cycle; when count==1, count SHALL become 0 and the FSM SHALL go to DONE.
REQ-019 In RUN with pause=1, count and state SHALL hold.
REQ-020 With no pause, done SHALL be high exactly N edges after the edge that samples start, where N is the loaded value.
REQ-021 done SHALL be 1 only in DONE and SHALL last exactly one cycle; busy SHALL be 1 only in RUN.
REQ-022 Decrement SHALL be modulo 2^WIDTH, but count SHALL never wrap because the 1->0 transition terminates RUN.
REQ-023 abort SHALL have priority over pause, load and start in ARMED, RUN and DONE, forcing IDLE with count=0 on the next edge; in DONE, done still completes its current cycle.
REQ-024 start, pause and abort SHALL be ignored in IDLE.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL enter IDLE with count=0, reload register=0, done=0, busy=0 and load_ready=1; reset SHALL override all other inputs, including during RUN.

Configuration
REQ-026 Macro COUNTDOWN_TIMER_AUTORELOAD_EN defined: DONE SHALL go to RUN with count=reload register, giving a done period of N+1 cycles; if reload==0, DONE SHALL go to IDLE.
REQ-027 Macro COUNTDOWN_TIMER_AUTORELOAD_EN undefined: DONE SHALL always go to IDLE with count=0, and the reload register MAY be optimised away.

Structure
REQ-028 Shared package countdown_timer_pkg SHALL hold the FSM state encoding (2-bit: IDLE=0, ARMED=1, RUN=2, DONE=3) and the default WIDTH constant.
REQ-029 The block SHALL be a single module with no sub-module; the counter and FSM SHALL be in one sequential process plus combinational output decode.

Verification
REQ-030 Load 5, then start one cycle later, no pause -> busy for 5 cycles, count 5,4,3,2,1,0, done pulses once 5 edges after the start edge, then IDLE with load_ready=1.
REQ-031 Load 0, then start -> DONE on the next edge, done high for one cycle, busy never asserted.
REQ-032 Load 4, start, pause high for 3 cycles while count=2 -> count holds at 2 for 3 cycles, and done arrives 3 cycles later than without pause.
REQ-033 Load 10, start, abort while count=6 -> next edge gives IDLE, count=0, no done pulse; rst asserted mid-RUN gives the same result.
REQ-034 In ARMED, assert load_valid with value 7 and start together -> count=7, state stays ARMED; a later start runs 7 cycles.
REQ-035 With COUNTDOWN_TIMER_AUTORELOAD_EN defined, load 3 and start -> done pulses every 4 cycles repeatedly until abort; with the macro undefined, a single pulse only.
